jump_unit: RTL and testbench
============================

JUMP_UNIT -- requirements
Module: jump_unit

Interface
REQ-001 Parameter PC_WIDTH, default 32, program-counter and jump-target width (legal range 8..32).
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 iCLK  in  1  clock; all state updates on rising edge.
REQ-005 iRST_N  in  1  asynchronous active-low reset.
REQ-006 iVALID  in  1  input instruction valid.
REQ-007 oREADY  out  1  unit can accept an instruction this cycle.
REQ-008 iIR  in  32  instruction word.
REQ-009 iPC  in  PC_WIDTH  address of iIR.
REQ-010 iRS1  in  32  rs1 register value, used by JALR.
REQ-011 iFLUSH  in  1  cancel the held result and any same-cycle input.
REQ-012 oVALID  out  1  result register holds a valid result.
REQ-013 iREADY  in  1  downstream accepts the result.
REQ-014 oRD  out  5  destination register index iIR[11:7].
REQ-015 oWE  out  1  register write enable for oREG_IN.
REQ-016 oREG_IN  out  32  link value, zero-extended.
REQ-017 oPCBR  out  PC_WIDTH  jump target.
REQ-018 oMISALIGN  out  1  target not 4-byte aligned.
REQ-019 oILLEGAL  out  1  instruction is not a legal JAL or JALR.
REQ-020 oRAS_PRED  out  PC_WIDTH  predicted return target (RAS builds only).
REQ-021 oRAS_HIT  out  1  oRAS_PRED equals oPCBR on a RAS pop.

Function
REQ-022 oREADY SHALL equal !oVALID || iREADY; accept occurs when iVALID && oREADY && !iFLUSH.
REQ-023 Latency SHALL be one cycle: result registered on the accept edge, held stable while oVALID && !iREADY.
REQ-024 oVALID SHALL clear on the edge where iREADY=1 and no new accept occurs.
REQ-025 JAL (opcode 1101111): imm = sign-extended {iIR[31], iIR[19:12], iIR[20], iIR[30:21], 0}; target = iPC + imm, truncated mod 2^PC_WIDTH.
REQ-026 JALR (opcode 1100111, funct3 000): imm = sign-extended iIR[31:20]; target = (iRS1 + imm) truncated to PC_WIDTH with bit 0 forced to 0.
REQ-027 Link = (iPC + 4) mod 2^PC_WIDTH, zero-extended to 32 bits.
REQ-028 oWE SHALL be 1 only for a legal, aligned jump with rd != 0.
REQ-029 oMISALIGN SHALL be 1 when target bit 1 = 1; oPCBR still carries the computed target.
REQ-030 Any other opcode, or JALR with funct3 != 000: oILLEGAL=1, oWE=0, oMISALIGN=0, oPCBR=0, RAS untouched.
REQ-031 iFLUSH=1 SHALL clear oVALID on the next edge and discard same-cycle input; flush wins over accept and hold.

Reset
REQ-032 While iRST_N=0, oVALID, oWE, oMISALIGN, oILLEGAL, oRAS_HIT SHALL be 0; oRD, oREG_IN, oPCBR, oRAS_PRED SHALL be 0.
REQ-033 Reset SHALL empty the RAS (pointer 0, count 0); reset mid-hold drops the held result.

Configuration
REQ-034 Macro JUMP_UNIT_RAS_EN SHALL include the return-address stack; when undefined, oRAS_PRED and oRAS_HIT SHALL be tied to 0 and no RAS storage exists.
REQ-035 RAS link regs are x1 and x5; on accept of a legal, aligned jump: push link if rd is a link reg; pop if JALR and rs1 is a link reg and rs1 != rd; pop then push if both apply and rs1 != rd; push only if rs1 == rd.
REQ-036 Push on a full RAS SHALL overwrite the oldest entry (pointer wraps), count saturates at RAS_DEPTH.
REQ-037 Pop on an empty RAS SHALL give oRAS_PRED=0 and oRAS_HIT=0; count stays 0.
REQ-038 RAS updates occur on accept only; a later flush does not roll them back.

Verification
REQ-039 Reset, then JAL x1,+8 at iPC=0x100 -> next cycle oVALID=1, oPCBR=0x108, oREG_IN=0x104, oRD=1, oWE=1.
REQ-040 JALR x0,4(x5) with iRS1=0x203 -> oPCBR=0x206, oMISALIGN=1, oWE=0.
REQ-041 Hold iREADY=0 for 3 cycles with a new iVALID -> oREADY=0, outputs stable; the pending input is accepted one cycle after iREADY=1.
REQ-042 RAS_EN: JAL x1 at 0x40, then JALR x0,0(x1) with iRS1=0x44 -> oRAS_PRED=0x44, oRAS_HIT=1; 5 pushes on depth 4 then 4 pops return newest-first, 5th pop gives oRAS_HIT=0.
REQ-043 iFLUSH together with iVALID while oVALID=1 -> oVALID=0 next cycle, no output of either instruction.
REQ-044 iIR=0x00000013 (ADDI) -> oILLEGAL=1, oWE=0, RAS count unchanged.

Source files
------------

// File: rtl/jump_unit.sv
// JAL/JALR execution unit: one-cycle registered result with valid/ready handshake and flush.
// Optional return-address stack is built when JUMP_UNIT_RAS_EN is defined.
module jump_unit #(
    parameter int PC_WIDTH  = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic                iVALID,
    output logic                oREADY,
    input  logic [31:0]         iIR,
    input  logic [PC_WIDTH-1:0] iPC,
    input  logic [31:0]         iRS1,
    input  logic                iFLUSH,
    output logic                oVALID,
    input  logic                iREADY,
    output logic [4:0]          oRD,
    output logic                oWE,
    output logic [31:0]         oREG_IN,
    output logic [PC_WIDTH-1:0] oPCBR,
    output logic                oMISALIGN,
    output logic                oILLEGAL,
    output logic [PC_WIDTH-1:0] oRAS_PRED,
    output logic                oRAS_HIT
);

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic                r_valid;
    logic [4:0]          r_rd;
    logic                r_we;
    logic [31:0]         r_reg_in;
    logic [PC_WIDTH-1:0] r_pcbr;
    logic                r_misalign;
    logic                r_illegal;

    logic [4:0]          w_rd;
    logic                w_is_jal;
    logic                w_is_jalr;
    logic                w_legal;
    logic [31:0]         w_jal_imm;
    logic [31:0]         w_jalr_imm;
    logic [PC_WIDTH-1:0] w_jal_sum;
    logic [PC_WIDTH-1:0] w_jalr_sum;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_link_pc;
    logic                w_misalign;
    logic                w_ok;
    logic                w_we;
    logic                w_accept;

    assign w_rd       = iIR[11:7];
    assign w_is_jal   = (iIR[6:0] == OP_JAL);
    assign w_is_jalr  = (iIR[6:0] == OP_JALR) && (iIR[14:12] == 3'b000);
    assign w_legal    = w_is_jal || w_is_jalr;

    assign w_jal_imm  = {{11{iIR[31]}}, iIR[31], iIR[19:12], iIR[20], iIR[30:21], 1'b0};
    assign w_jalr_imm = {{20{iIR[31]}}, iIR[31:20]};

    // Sums are formed directly at PC_WIDTH so the modulo-2^PC_WIDTH wrap is implicit.
    assign w_jal_sum  = iPC + w_jal_imm[PC_WIDTH-1:0];
    assign w_jalr_sum = iRS1[PC_WIDTH-1:0] + w_jalr_imm[PC_WIDTH-1:0];
    assign w_link_pc  = iPC + PC_WIDTH'(4);

    always_comb begin
        w_target = '0;
        if (w_is_jal) begin
            w_target = w_jal_sum;
        end else if (w_is_jalr) begin
            w_target = w_jalr_sum & ~PC_WIDTH'(1);
        end
    end

    assign w_misalign = w_legal && w_target[1];
    assign w_ok       = w_legal && !w_target[1];
    assign w_we       = w_ok && (w_rd != 5'd0);

    assign oREADY   = !r_valid || iREADY;
    assign w_accept = iVALID && oREADY && !iFLUSH;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_valid    <= 1'b0;
            r_rd       <= '0;
            r_we       <= 1'b0;
            r_reg_in   <= '0;
            r_pcbr     <= '0;
            r_misalign <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (iFLUSH) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_rd       <= w_rd;
            r_we       <= w_we;
            r_reg_in   <= w_legal ? 32'(w_link_pc) : 32'd0;
            r_pcbr     <= w_target;
            r_misalign <= w_misalign;
            r_illegal  <= !w_legal;
        end else if (iREADY) begin
            r_valid <= 1'b0;
        end
    end

    assign oVALID    = r_valid;
    assign oRD       = r_rd;
    assign oWE       = r_we;
    assign oREG_IN   = r_reg_in;
    assign oPCBR     = r_pcbr;
    assign oMISALIGN = r_misalign;
    assign oILLEGAL  = r_illegal;

`ifdef JUMP_UNIT_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W:0]      r_cnt;
    logic [PC_WIDTH-1:0] r_ras_pred;
    logic                r_ras_hit;

    logic [4:0]          w_rs1;
    logic                w_rd_link;
    logic                w_rs1_link;
    logic                w_pop;
    logic                w_push;
    logic                w_can_pop;
    logic [PTR_W-1:0]    w_top_idx;
    logic [PC_WIDTH-1:0] w_pred;
    logic                w_hit;
    logic [PTR_W-1:0]    w_ptr_mid;
    logic [PTR_W:0]      w_cnt_mid;
    logic [PTR_W-1:0]    w_ptr_next;
    logic [PTR_W:0]      w_cnt_next;

    assign w_rs1      = iIR[19:15];
    assign w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    assign w_pop      = w_ok && w_is_jalr && w_rs1_link && (w_rs1 != w_rd);
    assign w_push     = w_ok && w_rd_link;

    assign w_can_pop  = w_pop && (r_cnt != '0);
    assign w_top_idx  = r_ptr - PTR_W'(1);
    assign w_pred     = w_can_pop ? r_ras[w_top_idx] : '0;
    assign w_hit      = w_can_pop && (w_pred == w_target);

    // A pop-then-push reuses the popped slot, so the push lands on the post-pop pointer.
    assign w_ptr_mid  = w_can_pop ? w_top_idx : r_ptr;
    assign w_cnt_mid  = w_can_pop ? (r_cnt - (PTR_W+1)'(1)) : r_cnt;

    always_comb begin
        w_ptr_next = w_ptr_mid;
        w_cnt_next = w_cnt_mid;
        if (w_push) begin
            w_ptr_next = w_ptr_mid + PTR_W'(1);
            if (w_cnt_mid != (PTR_W+1)'(RAS_DEPTH)) begin
                w_cnt_next = w_cnt_mid + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_ras_pred <= '0;
            r_ras_hit  <= 1'b0;
        end else if (w_accept) begin
            r_ptr      <= w_ptr_next;
            r_cnt      <= w_cnt_next;
            r_ras_pred <= w_pred;
            r_ras_hit  <= w_hit;
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_accept && w_push) begin
            r_ras[w_ptr_mid] <= w_link_pc;
        end
    end

    assign oRAS_PRED = r_ras_pred;
    assign oRAS_HIT  = r_ras_hit;
`else
    assign oRAS_PRED = '0;
    assign oRAS_HIT  = 1'b0;
`endif

endmodule

// File: tb/tb_jump_unit.sv
// Self-checking bench for jump_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the jump/link/RAS rules.
module tb_jump_unit;

    localparam int PW = 24;
    localparam int D  = 4;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iVALID = 1'b0;
    logic          oREADY;
    logic [31:0]   iIR = '0;
    logic [PW-1:0] iPC = '0;
    logic [31:0]   iRS1 = '0;
    logic          iFLUSH = 1'b0;
    logic          oVALID;
    logic          iREADY = 1'b0;
    logic [4:0]    oRD;
    logic          oWE;
    logic [31:0]   oREG_IN;
    logic [PW-1:0] oPCBR;
    logic          oMISALIGN;
    logic          oILLEGAL;
    logic [PW-1:0] oRAS_PRED;
    logic          oRAS_HIT;

    jump_unit #(.PC_WIDTH(PW), .RAS_DEPTH(D)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iVALID(iVALID), .oREADY(oREADY),
        .iIR(iIR), .iPC(iPC), .iRS1(iRS1), .iFLUSH(iFLUSH), .oVALID(oVALID),
        .iREADY(iREADY), .oRD(oRD), .oWE(oWE), .oREG_IN(oREG_IN), .oPCBR(oPCBR),
        .oMISALIGN(oMISALIGN), .oILLEGAL(oILLEGAL), .oRAS_PRED(oRAS_PRED),
        .oRAS_HIT(oRAS_HIT)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit            m_valid;
    logic [4:0]    m_rd;
    bit            m_we, m_mis, m_ill, m_ras_hit;
    logic [31:0]   m_regin;
    logic [PW-1:0] m_pcbr, m_ras_pred;
    logic [PW-1:0] ras_q[$];
    logic          obs_ready;
    bit            exp_ready;

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm, input logic [2:0] f3);
        return {imm, rs1, f3, rd, 7'b1100111};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rd = 0; m_we = 0; m_mis = 0; m_ill = 0;
        m_regin = 0; m_pcbr = 0; m_ras_pred = 0; m_ras_hit = 0;
        ras_q.delete();
    endtask

    task automatic model_accept(input logic [31:0] ir, input logic [PW-1:0] pc, input logic [31:0] rs1);
        bit jal, jalr, pop, push;
        logic signed [20:0] jimm;
        logic signed [11:0] iimm;
        logic [PW-1:0] tgt, link, top;
        int rd, r1;
        jal  = (ir[6:0] == 7'b1101111);
        jalr = (ir[6:0] == 7'b1100111) && (ir[14:12] == 3'b000);
        rd = int'(ir[11:7]);
        r1 = int'(ir[19:15]);
        jimm = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        iimm = ir[31:20];
        link = PW'(longint'(pc) + 4);
        m_rd = ir[11:7];
        m_ras_pred = 0;
        m_ras_hit = 0;
        if (!(jal || jalr)) begin
            m_ill = 1; m_we = 0; m_mis = 0; m_pcbr = 0;
            return;
        end
        if (jal) tgt = PW'(longint'(pc) + longint'(jimm));
        else begin
            tgt = PW'(longint'(rs1) + longint'(iimm));
            tgt[0] = 1'b0;
        end
        m_ill = 0;
        m_pcbr = tgt;
        m_mis = tgt[1];
        m_regin = 32'(link);
        m_we = !m_mis && rd != 0;
`ifdef JUMP_UNIT_RAS_EN
        if (!m_mis) begin
            pop  = jalr && (r1 == 1 || r1 == 5) && r1 != rd;
            push = (rd == 1 || rd == 5);
            if (pop && ras_q.size() > 0) begin
                top = ras_q.pop_back();
                m_ras_pred = top;
                m_ras_hit = (top == tgt);
            end
            if (push) begin
                ras_q.push_back(link);
                if (ras_q.size() > D) void'(ras_q.pop_front());
            end
        end
`else
        pop = 0; push = 0; top = 0;
        if (pop || push || top != 0 || r1 < 0) m_ras_hit = 0;
`endif
    endtask

    // Drives one clock of stimulus and advances the model; leaves time at edge+1.
    task automatic cycle(input bit v, input logic [31:0] ir, input logic [PW-1:0] pc,
                         input logic [31:0] rs1, input bit fl, input bit rdy);
        bit acc;
        iVALID = v; iIR = ir; iPC = pc; iRS1 = rs1; iFLUSH = fl; iREADY = rdy;
        #1;
        obs_ready = oREADY;
        exp_ready = !m_valid || rdy;
        acc = v && exp_ready && !fl;
        @(posedge iCLK);
        if (fl) m_valid = 0;
        else if (acc) begin
            model_accept(ir, pc, rs1);
            m_valid = 1;
            $display("txn ir=%h pc=%h rs1=%h -> pcbr=%h we=%0d mis=%0d ill=%0d",
                     ir, pc, rs1, m_pcbr, m_we, m_mis, m_ill);
        end else if (rdy) m_valid = 0;
        #1;
    endtask

    task automatic do_reset();
        iRST_N = 0; iVALID = 0; iFLUSH = 0; iREADY = 0;
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        iRST_N = 1;
    endtask

    task automatic test_reset();
        iRST_N = 0; iVALID = 1; iREADY = 1; iIR = enc_jal(5'd1, 21'h10); iPC = 24'h100;
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        total++; if (oVALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", oVALID); end
        total++; if ({oWE, oMISALIGN, oILLEGAL, oRAS_HIT} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {oWE, oMISALIGN, oILLEGAL, oRAS_HIT}); end
        total++; if (oRD !== 5'd0 || oREG_IN !== 32'd0) begin bad++; $display("FAIL reset_rd_regin got=%h/%h exp=0/0", oRD, oREG_IN); end
        total++; if (oPCBR !== '0 || oRAS_PRED !== '0) begin bad++; $display("FAIL reset_pcbr_pred got=%h/%h exp=0/0", oPCBR, oRAS_PRED); end
        iRST_N = 1; iVALID = 0;
    endtask

    task automatic test_jal_basic();
        do_reset();
        cycle(1, enc_jal(5'd1, 21'd8), 24'h100, 32'd0, 0, 1);
        total++; if (oVALID !== 1'b1) begin bad++; $display("FAIL jal_valid got=%b exp=1", oVALID); end
        total++; if (oPCBR !== 24'h108) begin bad++; $display("FAIL jal_pcbr got=%h exp=108", oPCBR); end
        total++; if (oREG_IN !== 32'h104) begin bad++; $display("FAIL jal_link got=%h exp=104", oREG_IN); end
        total++; if (oRD !== 5'd1 || oWE !== 1'b1) begin bad++; $display("FAIL jal_rd_we got=%0d/%b exp=1/1", oRD, oWE); end
        cycle(1, enc_jal(5'd2, 21'h1FFFF0), 24'h000004, 32'd0, 0, 1);
        total++; if (oPCBR !== 24'hFFFFF4) begin bad++; $display("FAIL jal_wrap got=%h exp=fffff4", oPCBR); end
        cycle(1, enc_jal(5'd3, 21'd8), 24'hFFFFFC, 32'd0, 0, 1);
        total++; if (oREG_IN !== 32'h0 || oPCBR !== 24'h000004) begin bad++; $display("FAIL link_wrap got=%h/%h exp=0/4", oREG_IN, oPCBR); end
    endtask

    task automatic test_jalr_misalign();
        cycle(1, enc_jalr(5'd0, 5'd5, 12'd4, 3'b000), 24'h300, 32'h203, 0, 1);
        total++; if (oPCBR !== 24'h206 || oMISALIGN !== 1'b1) begin bad++; $display("FAIL jalr_mis got=%h/%b exp=206/1", oPCBR, oMISALIGN); end
        total++; if (oWE !== 1'b0 || oILLEGAL !== 1'b0) begin bad++; $display("FAIL jalr_mis_we got=%b/%b exp=0/0", oWE, oILLEGAL); end
        cycle(1, enc_jalr(5'd7, 5'd9, 12'hFFC, 3'b000), 24'h300, 32'h1005, 0, 1);
        total++; if (oPCBR !== 24'h1000 || oMISALIGN !== 1'b0 || oWE !== 1'b1) begin bad++; $display("FAIL jalr_neg got=%h/%b/%b exp=1000/0/1", oPCBR, oMISALIGN, oWE); end
    endtask

    task automatic test_illegal();
        cycle(1, 32'h00000013, 24'h400, 32'h0, 0, 1);
        total++; if ({oILLEGAL, oWE, oMISALIGN} !== 3'b100 || oPCBR !== '0) begin bad++; $display("FAIL illegal_addi got=%b/%h exp=100/0", {oILLEGAL, oWE, oMISALIGN}, oPCBR); end
        cycle(1, enc_jalr(5'd1, 5'd1, 12'd0, 3'b010), 24'h400, 32'h80, 0, 1);
        total++; if ({oILLEGAL, oWE, oMISALIGN} !== 3'b100 || oPCBR !== '0) begin bad++; $display("FAIL illegal_f3 got=%b/%h exp=100/0", {oILLEGAL, oWE, oMISALIGN}, oPCBR); end
    endtask

    task automatic test_backpressure();
        do_reset();
        cycle(1, enc_jal(5'd1, 21'd8), 24'h100, 32'd0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, enc_jal(5'd2, 21'h40), 24'h200, 32'd0, 0, 0);
            total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=0", k, obs_ready); end
            total++; if (oVALID !== 1'b1 || oPCBR !== 24'h108 || oRD !== 5'd1) begin bad++; $display("FAIL hold_stable[%0d] got=%b/%h/%0d exp=1/108/1", k, oVALID, oPCBR, oRD); end
        end
        cycle(1, enc_jal(5'd2, 21'h40), 24'h200, 32'd0, 0, 1);
        total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", obs_ready); end
        total++; if (oVALID !== 1'b1 || oPCBR !== 24'h240 || oRD !== 5'd2) begin bad++; $display("FAIL release_next got=%b/%h/%0d exp=1/240/2", oVALID, oPCBR, oRD); end
        cycle(0, 32'h0, 24'h0, 32'd0, 0, 1);
        total++; if (oVALID !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", oVALID); end
    endtask

    task automatic test_flush();
        cycle(1, enc_jal(5'd1, 21'd8), 24'h500, 32'd0, 0, 0);
        cycle(1, enc_jal(5'd5, 21'd16), 24'h600, 32'd0, 1, 0);
        total++; if (oVALID !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", oVALID); end
        cycle(0, 32'h0, 24'h0, 32'd0, 0, 0);
        total++; if (oVALID !== 1'b0) begin bad++; $display("FAIL flush_after got=%b exp=0", oVALID); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        cycle(1, enc_jal(5'd1, 21'd8), 24'h700, 32'd0, 0, 0);
        iRST_N = 0;
        #1;
        total++; if (oVALID !== 1'b0 || oPCBR !== '0) begin bad++; $display("FAIL reset_hold got=%b/%h exp=0/0", oVALID, oPCBR); end
        do_reset();
        cycle(1, enc_jalr(5'd0, 5'd1, 12'd0, 3'b000), 24'h800, 32'h704, 0, 1);
        total++; if (oRAS_PRED !== '0 || oRAS_HIT !== 1'b0) begin bad++; $display("FAIL ras_empty_after_reset got=%h/%b exp=0/0", oRAS_PRED, oRAS_HIT); end
    endtask

    task automatic test_ras();
        logic [PW-1:0] exp_pred;
        do_reset();
        cycle(1, enc_jal(5'd1, 21'h20), 24'h40, 32'd0, 0, 1);
        cycle(1, enc_jalr(5'd0, 5'd1, 12'd0, 3'b000), 24'h60, 32'h44, 0, 1);
`ifdef JUMP_UNIT_RAS_EN
        total++; if (oRAS_PRED !== 24'h44 || oRAS_HIT !== 1'b1) begin bad++; $display("FAIL ras_ret got=%h/%b exp=44/1", oRAS_PRED, oRAS_HIT); end
        for (int k = 1; k <= 5; k++)
            cycle(1, enc_jal(5'd1, 21'd8), PW'(k * 32'h1000), 32'd0, 0, 1);
        for (int k = 5; k >= 1; k--) begin
            cycle(1, enc_jalr(5'd0, 5'd1, 12'd0, 3'b000), 24'h9000, k * 32'h1000 + 32'h4, 0, 1);
            exp_pred = (k >= 2) ? PW'(k * 32'h1000 + 32'h4) : '0;
            total++; if (oRAS_PRED !== exp_pred || oRAS_HIT !== (k >= 2)) begin bad++; $display("FAIL ras_pop[%0d] got=%h/%b exp=%h/%b", k, oRAS_PRED, oRAS_HIT, exp_pred, k >= 2); end
        end
`else
        exp_pred = '0;
        total++; if (oRAS_PRED !== exp_pred || oRAS_HIT !== 1'b0) begin bad++; $display("FAIL ras_tied got=%h/%b exp=0/0", oRAS_PRED, oRAS_HIT); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] ir, rs1v;
        logic [4:0] rd, rs;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rd = ($urandom_range(2) == 0) ? 5'($urandom) : (($urandom_range(1) == 0) ? 5'd1 : 5'd5);
            rs = ($urandom_range(2) == 0) ? 5'($urandom) : (($urandom_range(1) == 0) ? 5'd1 : 5'd5);
            rs1v = $urandom;
            case ($urandom_range(5))
                0, 1: ir = enc_jal(rd, 21'($urandom));
                2, 3: begin
                    if (ras_q.size() > 0 && $urandom_range(1) == 1) begin
                        rs1v = 32'(ras_q[$]);
                        ir = enc_jalr(rd, rs, 12'd0, 3'b000);
                    end else ir = enc_jalr(rd, rs, 12'($urandom), 3'b000);
                end
                4: ir = enc_jalr(rd, rs, 12'($urandom), 3'($urandom_range(7, 1)));
                default: ir = {$urandom_range(32'h1FFFFFF), 7'b0010011};
            endcase
            cycle($urandom_range(3) != 0, ir, PW'($urandom), rs1v,
                  $urandom_range(19) == 0, $urandom_range(9) < 7);
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, obs_ready, exp_ready); end
            total++; if (oVALID !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, oVALID, m_valid); end
            if (m_valid) begin
                total++;
                if (oRD !== m_rd || oWE !== m_we || oPCBR !== m_pcbr || oMISALIGN !== m_mis || oILLEGAL !== m_ill) begin
                    bad++; $display("FAIL rnd_result[%0d] got=%0d/%b/%h/%b/%b exp=%0d/%b/%h/%b/%b",
                                    n, oRD, oWE, oPCBR, oMISALIGN, oILLEGAL, m_rd, m_we, m_pcbr, m_mis, m_ill);
                end
                total++;
                if ((!m_ill && oREG_IN !== m_regin) || oRAS_PRED !== m_ras_pred || oRAS_HIT !== m_ras_hit) begin
                    bad++; $display("FAIL rnd_link_ras[%0d] got=%h/%h/%b exp=%h/%h/%b",
                                    n, oREG_IN, oRAS_PRED, oRAS_HIT, m_regin, m_ras_pred, m_ras_hit);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_jal_basic();
        test_jalr_misalign();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid_hold();
        test_ras();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
